// File: rtl/uart_dev_pkg.sv
// Shared constants for the UART transmitter peripheral: register indices,
// STATUS/CTRL bit positions and transmitter FSM state encodings.
package uart_dev_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_EMPTY_BIT = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_BUSY_BIT  = 2;
  localparam int ST_OVF_BIT   = 3;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO for the UART transmitter; pointers carry one
// extra wrap bit so full and empty are told apart without a counter.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, baud counter,
// shift register and frame FSM, with a level interrupt when the path drains.
module uart_tx_dev
  import uart_dev_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [3:0]  ByteEn,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        txd
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);

  logic [1:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          en;
  logic          irq_en;
  logic          overflow;
  logic          fifo_empty;
  logic          fifo_full;
  logic [7:0]    fifo_dout;
  logic          wr;
  logic          push;
  logic          pop;
  logic          stat_wr;
  logic          ctrl_wr;
  logic          baud_done;
  logic          unused_bus;

  assign unused_bus = ^{Addr[29:2], ByteEn[3:1], Din[31:8]};

  assign wr        = WE && ByteEn[0];
  assign push      = wr && (Addr[1:0] == REG_DATA);
  assign stat_wr   = wr && (Addr[1:0] == REG_STATUS);
  assign ctrl_wr   = wr && (Addr[1:0] == REG_CTRL);
  assign pop       = (state == S_IDLE) && en && !fifo_empty;
  assign baud_done = (baud_cnt == BAUD_LAST);
  assign IRQ       = irq_en && fifo_empty && (state == S_IDLE);

  uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (Din[7:0]),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Overflow is judged on the pre-edge fullness, so a same-edge pop cannot save the byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en       <= 1'b0;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        en     <= Din[CTRL_EN_BIT];
        irq_en <= Din[CTRL_IRQ_EN_BIT];
      end
      if (stat_wr)               overflow <= 1'b0;
      else if (push && fifo_full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      txd      <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            state    <= S_START;
            baud_cnt <= '0;
            txd      <= 1'b0;
          end
        end
        S_START: begin
          if (baud_done) begin
            state    <= S_DATA;
            baud_cnt <= '0;
            bit_idx  <= '0;
            txd      <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          if (baud_done) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // shreg[0] always holds the bit currently on the line once DATA begins.
  always_ff @(posedge clk) begin
    if (pop)                             shreg <= fifo_dout;
    else if (state == S_DATA && baud_done) shreg <= {1'b0, shreg[7:1]};
  end

  always_comb begin
    Dout = '0;
    case (Addr[1:0])
      REG_STATUS: begin
        Dout[ST_EMPTY_BIT] = fifo_empty;
        Dout[ST_FULL_BIT]  = fifo_full;
        Dout[ST_BUSY_BIT]  = (state != S_IDLE);
        Dout[ST_OVF_BIT]   = overflow;
      end
      REG_CTRL: begin
        Dout[CTRL_EN_BIT]     = en;
        Dout[CTRL_IRQ_EN_BIT] = irq_en;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed bench for uart_tx_dev with CLK_DIV=4, FIFO_DEPTH=4.
module tb_uart_tx_dev;
  localparam int CLK_DIV = 4;
  localparam int FIFO_DEPTH = 4;
  localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_CTRL = 2'd2, A_RSVD = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] Addr;
  logic        WE;
  logic [3:0]  ByteEn;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;
  logic        txd;

  int n_cmp = 0;
  int n_fail = 0;

  uart_tx_dev #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .Addr   (Addr),
    .WE     (WE),
    .ByteEn (ByteEn),
    .Din    (Din),
    .Dout   (Dout),
    .IRQ    (IRQ),
    .txd    (txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr = {28'd0, a};
    Din = d;
    WE = 1'b1;
    ByteEn = 4'h1;
    @(posedge clk);
    #1;
    WE = 1'b0;
    ByteEn = 4'h0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    Addr = {28'd0, a};
    #1;
    check(tag, Dout, exp);
  endtask

  // Entered just after the edge into START (minus skip elapsed cycles) with Addr=STATUS;
  // returns just after the edge back into IDLE.
  task automatic run_frame(input logic [7:0] b, input int skip, input logic irq_idle);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = skip; i < 10 * CLK_DIV; i++) begin
      @(negedge clk);
      check("txd_bit", {31'd0, txd}, {31'd0, fr[i / CLK_DIV]});
      check("busy_frame", {31'd0, Dout[2]}, 32'd1);
      check("irq_frame", {31'd0, IRQ}, 32'd0);
    end
    @(posedge clk);
    #1;
    check("idle_txd", {31'd0, txd}, 32'd1);
    check("idle_busy", {31'd0, Dout[2]}, 32'd0);
    check("idle_irq", {31'd0, IRQ}, {31'd0, irq_idle});
  endtask

  initial begin
    reset = 1'b0;
    Addr = '0;
    WE = 1'b0;
    ByteEn = 4'h0;
    Din = '0;
    #12;
    read_check("rst_status", A_STATUS, 32'h1);
    read_check("rst_ctrl", A_CTRL, 32'h0);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_irq", {31'd0, IRQ}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Reserved and DATA reads, reserved write ignored
    bus_write(A_RSVD, 32'hFFFF_FFFF);
    read_check("rsvd_read", A_RSVD, 32'h0);
    read_check("data_read", A_DATA, 32'h0);
    read_check("ctrl_after_rsvd", A_CTRL, 32'h0);
    read_check("status_after_rsvd", A_STATUS, 32'h1);

    // Single frame 0xA5
    bus_write(A_CTRL, 32'h1);
    read_check("ctrl_en", A_CTRL, 32'h1);
    bus_write(A_DATA, 32'h0000_00A5);
    Addr = {28'd0, A_STATUS};
    #1;
    check("push_status", Dout, 32'h0);
    check("push_txd", {31'd0, txd}, 32'd1);
    @(posedge clk);
    #1;
    run_frame(8'hA5, 0, 1'b0);
    read_check("a5_done", A_STATUS, 32'h1);

    // Three back-to-back bytes
    bus_write(A_DATA, 32'h01);
    bus_write(A_DATA, 32'h02);
    bus_write(A_DATA, 32'h03);
    Addr = {28'd0, A_STATUS};
    run_frame(8'h01, 1, 1'b0);
    @(posedge clk);
    #1;
    run_frame(8'h02, 0, 1'b0);
    @(posedge clk);
    #1;
    run_frame(8'h03, 0, 1'b0);
    read_check("b2b_done", A_STATUS, 32'h1);

    // Fill with en=0, overflow on the fifth push
    bus_write(A_CTRL, 32'h0);
    for (int i = 0; i < 5; i++) bus_write(A_DATA, 32'h10 + i);
    read_check("ovf_status", A_STATUS, 32'hA);
    bus_write(A_STATUS, 32'h0);
    read_check("ovf_cleared", A_STATUS, 32'h2);
    bus_write(A_CTRL, 32'h1);
    Addr = {28'd0, A_STATUS};
    @(posedge clk);
    #1;
    run_frame(8'h10, 0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      #1;
      run_frame(8'h10 + i[7:0], 0, 1'b0);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("drain_txd", {31'd0, txd}, 32'd1);
      check("drain_status", Dout, 32'h1);
    end

    // Interrupt behaviour
    bus_write(A_CTRL, 32'h3);
    read_check("ctrl_3", A_CTRL, 32'h3);
    check("irq_idle_on", {31'd0, IRQ}, 32'd1);
    bus_write(A_DATA, 32'h5A);
    check("irq_drop", {31'd0, IRQ}, 32'd0);
    Addr = {28'd0, A_STATUS};
    @(posedge clk);
    #1;
    run_frame(8'h5A, 0, 1'b1);
    bus_write(A_CTRL, 32'h1);
    check("irq_disable", {31'd0, IRQ}, 32'd0);

    // Reset mid-frame
    bus_write(A_DATA, 32'h00);
    bus_write(A_DATA, 32'h77);
    Addr = {28'd0, A_STATUS};
    repeat (10) @(negedge clk);
    check("mid_txd_low", {31'd0, txd}, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("async_txd", {31'd0, txd}, 32'd1);
    check("async_status", Dout, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    read_check("post_rst_ctrl", A_CTRL, 32'h0);
    read_check("post_rst_status", A_STATUS, 32'h1);
    bus_write(A_CTRL, 32'h1);
    Addr = {28'd0, A_STATUS};
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("no_residual_txd", {31'd0, txd}, 32'd1);
      check("no_residual_status", Dout, 32'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_dev.md
# uart_tx_dev

Memory-mapped UART transmitter peripheral sitting behind the system bridge beside the two timers, responding to the CPU's data-bus writes/reads. Buffers bytes in a small FIFO, serialises them 8N1 LSB-first on `txd`, and raises a level interrupt on a `HWInt` line when the transmitter drains. The bus side matches the timer register interface (word address, write enable, combinational read data).

## Interface
Parameters:
- `CLK_DIV`, 16: clock cycles per serial bit (≥2)
- `FIFO_DEPTH`, 4: TX FIFO entries (power of two, ≥2)

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `Addr`  in  30  word address (byte address [31:2]); only `Addr[1:0]` decoded
- `WE`  in  1  write strobe from bridge, sampled on rising edge
- `ByteEn`  in  4  byte enables; every register uses byte 0 only, writes ignored unless `ByteEn[0]`
- `Din`  in  32  write data
- `Dout`  out  32  read data, combinational from `Addr` and state
- `IRQ`  out  1  level interrupt request
- `txd`  out  1  serial output, registered, idle high

## Operation
- Register map (`Addr[1:0]`): 0 DATA, 1 STATUS, 2 CTRL, 3 reserved.
- DATA write: push `Din[7:0]`. DATA read returns 0.
- STATUS read: bit0 empty, bit1 full, bit2 busy (FSM ≠ IDLE), bit3 overflow (sticky), others 0. Any STATUS write clears overflow.
- CTRL read/write: bit0 `en`, bit1 `irq_en`; others read 0.
- Reserved: reads 0, writes ignored.
- Push while full: byte dropped, overflow set. Fullness judged before the edge; a same-edge pop does not rescue the push.
- FSM states IDLE, START, DATA, STOP; each bit lasts `CLK_DIV` cycles via a baud counter 0..CLK_DIV-1.
- IDLE → START when `en` && !empty: pop head into 8-bit shift register, counter cleared.
- START (`txd`=0) → DATA after CLK_DIV cycles; DATA shifts out bit0 first, 8 bits, bit index 0..7; → STOP (`txd`=1) → IDLE after CLK_DIV cycles.
- Clearing `en` mid-frame: current frame completes, no further pops.
- `IRQ` = `irq_en` && empty && state==IDLE. Level; cleared by writing a byte, or by clearing `irq_en`.

## Timing
- Reset (async assert): `txd`=1, state IDLE, FIFO empty, overflow 0, `en`=0, `irq_en`=0, counter 0, hence `IRQ`=0, `Dout` per map (STATUS reads 0x1).
- Register writes take effect at the sampling edge; `Dout` reflects them immediately after.
- Push at edge k with `en`=1 and FSM idle: edge k+1 enters START, `txd` falls after edge k+1.
- Frame = 10·CLK_DIV cycles of `txd`; back-to-back frames separated by exactly one IDLE cycle (`txd`=1).
- STATUS.busy rises after edge k+1, falls on the edge that returns to IDLE; `IRQ` rises that same edge if FIFO empty and `irq_en`.
- FIFO pointers wrap modulo FIFO_DEPTH; extra pointer bit distinguishes full/empty.
- Reset mid-frame: `txd` goes high asynchronously, frame abandoned, FIFO flushed.

## Structure
- Package `uart_dev_pkg`: register index constants (DATA/STATUS/CTRL), STATUS/CTRL bit positions, FSM state enum.
- Sub-module `uart_tx_fifo`: synchronous FIFO (push, pop, din, dout, empty, full), same clock/reset, width 8, depth parameter.
- Top holds register decode, baud counter, shift register, FSM.

## Test plan
- Reset, read STATUS/CTRL → 0x1/0x0, `txd`=1, `IRQ`=0.
- CTRL=0x1, CLK_DIV=4, write DATA=0xA5 → `txd` one cycle later: 0, 1,0,1,0,0,1,0,1, 1, each 4 cycles; busy high during 40 cycles.
- Write 3 bytes 0x01,0x02,0x03 back-to-back → three frames, 1 idle cycle between each; STATUS ends 0x1.
- `en`=0, write 5 bytes (depth 4) → STATUS=0xA (full+overflow); STATUS write → 0x2; set `en` → exactly 4 frames.
- CTRL=0x3, one byte → `IRQ` low during frame, high on return to IDLE; DATA write drops `IRQ` next cycle.
- Assert reset at mid-DATA bit → `txd` high immediately, STATUS=0x1 after release, no residual frame.
